// File: rtl/demux_pkg.sv
// Shared constants and helpers for the stream demultiplexer.
package demux_pkg;

   localparam int DROP_CNT_W = 8;

   function automatic logic sel_in_range(input int unsigned sel, input int unsigned m);
      return sel < m;
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output slot: loads on accept, clears on drain, data held until overwritten.
module demux_slot #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [N-1:0] load_data,
   input  logic         drain,
   output logic         valid,
   output logic [N-1:0] data,
   output logic         can_load
);

   // A drain in the same cycle frees the slot, so a new beat can enter without a bubble.
   assign can_load = ~valid | drain;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         data  <= '0;
      end else begin
         if (load) begin
            valid <= 1'b1;
            data  <= load_data;
         end else if (drain) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/demux_stream.sv
// 1-to-M stream demultiplexer with a registered slot per output and a drop counter
// for out-of-range selects.
module demux_stream
   import demux_pkg::*;
#(
   parameter  int N    = 8,
   parameter  int M    = 2,
   localparam int SELW = $clog2(M)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [N-1:0]          in_data,
   input  logic [SELW-1:0]       in_sel,
   output logic [M-1:0]          out_valid,
   input  logic [M-1:0]          out_ready,
   output logic [M*N-1:0]        out_data,
   output logic                  drop,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   logic [M-1:0] sel_hit;
   logic [M-1:0] can_load;
   logic [M-1:0] load;
   logic [M-1:0] drain;
   logic         in_range;
   logic         accept;
   logic         accept_drop;

   assign in_range    = sel_in_range(32'(in_sel), M);
   assign accept      = in_valid & in_ready;
   assign accept_drop = accept & ~in_range;

   // Out-of-range beats are always accepted so a bad select cannot wedge the producer.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         if (in_range) in_ready = |(sel_hit & can_load);
         else          in_ready = 1'b1;
      end
   end

   for (genvar k = 0; k < M; k++) begin : g_slot
      assign sel_hit[k] = (32'(in_sel) == k);
      assign load[k]    = accept & sel_hit[k];
      assign drain[k]   = out_valid[k] & out_ready[k];

      demux_slot #(.N(N)) u_slot (
         .clk       (clk),
         .reset     (reset),
         .load      (load[k]),
         .load_data (in_data),
         .drain     (drain[k]),
         .valid     (out_valid[k]),
         .data      (out_data[k*N +: N]),
         .can_load  (can_load[k])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         drop     <= 1'b0;
         drop_cnt <= '0;
      end else begin
         drop <= accept_drop;
         if (accept_drop && (drop_cnt != {DROP_CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_demux_stream.sv
// Directed bench for demux_stream: an M=2 instance for steering/back-pressure and an
// M=3 instance for out-of-range drops.
module tb_demux_stream;

   logic        clk = 1'b0;
   logic        reset;

   logic        in_valid2, in_ready2;
   logic [7:0]  in_data2;
   logic [0:0]  in_sel2;
   logic [1:0]  out_valid2, out_ready2;
   logic [15:0] out_data2;
   logic        drop2;
   logic [7:0]  drop_cnt2;

   logic        in_valid3, in_ready3;
   logic [7:0]  in_data3;
   logic [1:0]  in_sel3;
   logic [2:0]  out_valid3, out_ready3;
   logic [23:0] out_data3;
   logic        drop3;
   logic [7:0]  drop_cnt3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   demux_stream #(.N(8), .M(2)) dut2 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_sel(in_sel2),
      .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
      .drop(drop2), .drop_cnt(drop_cnt2)
   );

   demux_stream #(.N(8), .M(3)) dut3 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid3), .in_ready(in_ready3), .in_data(in_data3), .in_sel(in_sel3),
      .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
      .drop(drop3), .drop_cnt(drop_cnt3)
   );

   task automatic test_reset();
      reset = 1'b1;
      in_valid2 = 1'b1; in_sel2 = 1'b0; in_data2 = 8'hFF; out_ready2 = 2'b00;
      in_valid3 = 1'b1; in_sel3 = 2'd0; in_data3 = 8'hFF; out_ready3 = 3'b000;
      repeat (2) @(negedge clk);
      checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL reset_in_ready2 got %b want 0", in_ready2); end
      checks++; if (out_valid2 !== 2'b00) begin errors++; $display("FAIL reset_out_valid2 got %b want 00", out_valid2); end
      checks++; if (out_data2 !== 16'h0) begin errors++; $display("FAIL reset_out_data2 got %h want 0000", out_data2); end
      checks++; if (drop_cnt2 !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt2 got %0d want 0", drop_cnt2); end
      checks++; if (drop2 !== 1'b0) begin errors++; $display("FAIL reset_drop2 got %b want 0", drop2); end
      checks++; if (in_ready3 !== 1'b0) begin errors++; $display("FAIL reset_in_ready3 got %b want 0", in_ready3); end
      checks++; if (out_valid3 !== 3'b000) begin errors++; $display("FAIL reset_out_valid3 got %b want 000", out_valid3); end
      checks++; if (drop_cnt3 !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt3 got %0d want 0", drop_cnt3); end
      reset = 1'b0;
      in_valid2 = 1'b0;
      in_valid3 = 1'b0;
   endtask

   task automatic test_single();
      @(negedge clk);
      in_valid2 = 1'b1; in_sel2 = 1'b1; in_data2 = 8'hA5; out_ready2 = 2'b11;
      #1;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL single_in_ready got %b want 1", in_ready2); end
      @(negedge clk);
      in_valid2 = 1'b0;
      checks++; if (out_valid2 !== 2'b10) begin errors++; $display("FAIL single_out_valid got %b want 10", out_valid2); end
      checks++; if (out_data2[15:8] !== 8'hA5) begin errors++; $display("FAIL single_out_data got %h want a5", out_data2[15:8]); end
      @(negedge clk);
      checks++; if (out_valid2 !== 2'b00) begin errors++; $display("FAIL single_drained got %b want 00", out_valid2); end
      checks++; if (out_data2[15:8] !== 8'hA5) begin errors++; $display("FAIL single_data_held got %h want a5", out_data2[15:8]); end
   endtask

   task automatic test_stall();
      @(negedge clk);
      out_ready2 = 2'b00;
      in_valid2 = 1'b1; in_sel2 = 1'b0; in_data2 = 8'h11;
      #1;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_first_ready got %b want 1", in_ready2); end
      @(negedge clk);
      checks++; if (out_valid2 !== 2'b01) begin errors++; $display("FAIL stall_first_valid got %b want 01", out_valid2); end
      checks++; if (out_data2[7:0] !== 8'h11) begin errors++; $display("FAIL stall_first_data got %h want 11", out_data2[7:0]); end
      in_data2 = 8'h22;
      #1;
      checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_blocked_ready got %b want 0", in_ready2); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (out_data2[7:0] !== 8'h11) begin errors++; $display("FAIL stall_hold_data[%0d] got %h want 11", i, out_data2[7:0]); end
         checks++; if (out_valid2 !== 2'b01) begin errors++; $display("FAIL stall_hold_valid[%0d] got %b want 01", i, out_valid2); end
         #1;
         checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL stall_hold_ready[%0d] got %b want 0", i, in_ready2); end
      end
      out_ready2 = 2'b01;
      #1;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", in_ready2); end
      @(negedge clk);
      in_valid2 = 1'b0;
      out_ready2 = 2'b00;
      checks++; if (out_valid2 !== 2'b01) begin errors++; $display("FAIL stall_second_valid got %b want 01", out_valid2); end
      checks++; if (out_data2[7:0] !== 8'h22) begin errors++; $display("FAIL stall_second_data got %h want 22", out_data2[7:0]); end
      out_ready2 = 2'b11;
      @(negedge clk);
      checks++; if (out_valid2 !== 2'b00) begin errors++; $display("FAIL stall_final_drain got %b want 00", out_valid2); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] prev_data;
      logic       prev_sel;
      out_ready2 = 2'b11;
      prev_data = 8'h00;
      prev_sel = 1'b0;
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk);
         if (i > 1) begin
            checks++; if (out_valid2 !== (prev_sel ? 2'b10 : 2'b01)) begin errors++; $display("FAIL b2b_valid[%0d] got %b want sel %0d only", i - 1, out_valid2, prev_sel); end
            checks++; if (out_data2[prev_sel*8 +: 8] !== prev_data) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i - 1, out_data2[prev_sel*8 +: 8], prev_data); end
         end
         if (i <= 16) begin
            in_valid2 = 1'b1;
            in_data2  = 8'(i);
            in_sel2   = 1'((i - 1) % 2);
            prev_data = 8'(i);
            prev_sel  = in_sel2[0];
            #1;
            checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b want 1", i, in_ready2); end
         end else begin
            in_valid2 = 1'b0;
         end
      end
      @(negedge clk);
      checks++; if (out_valid2 !== 2'b00) begin errors++; $display("FAIL b2b_idle got %b want 00", out_valid2); end
   endtask

   task automatic test_drop();
      @(negedge clk);
      out_ready3 = 3'b000;
      in_valid3 = 1'b1; in_sel3 = 2'd2; in_data3 = 8'h5A;
      @(negedge clk);
      in_valid3 = 1'b0;
      checks++; if (out_valid3 !== 3'b100) begin errors++; $display("FAIL m3_sel2_valid got %b want 100", out_valid3); end
      checks++; if (out_data3[23:16] !== 8'h5A) begin errors++; $display("FAIL m3_sel2_data got %h want 5a", out_data3[23:16]); end
      checks++; if (drop3 !== 1'b0) begin errors++; $display("FAIL m3_sel2_nodrop got %b want 0", drop3); end
      in_valid3 = 1'b1; in_sel3 = 2'd3; in_data3 = 8'h77;
      #1;
      checks++; if (in_ready3 !== 1'b1) begin errors++; $display("FAIL drop_ready got %b want 1", in_ready3); end
      @(negedge clk);
      in_valid3 = 1'b0;
      checks++; if (drop3 !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", drop3); end
      checks++; if (drop_cnt3 !== 8'd1) begin errors++; $display("FAIL drop_cnt_one got %0d want 1", drop_cnt3); end
      checks++; if (out_valid3 !== 3'b100) begin errors++; $display("FAIL drop_no_slot_change got %b want 100", out_valid3); end
      checks++; if (out_data3[23:16] !== 8'h5A) begin errors++; $display("FAIL drop_data_kept got %h want 5a", out_data3[23:16]); end
      @(negedge clk);
      checks++; if (drop3 !== 1'b0) begin errors++; $display("FAIL drop_pulse_end got %b want 0", drop3); end
      checks++; if (drop_cnt3 !== 8'd1) begin errors++; $display("FAIL drop_cnt_hold got %0d want 1", drop_cnt3); end
      in_valid3 = 1'b1; in_sel3 = 2'd3;
      repeat (299) @(negedge clk);
      in_valid3 = 1'b0;
      checks++; if (drop_cnt3 !== 8'd255) begin errors++; $display("FAIL drop_cnt_sat got %0d want 255", drop_cnt3); end
      checks++; if (drop3 !== 1'b1) begin errors++; $display("FAIL drop_last_pulse got %b want 1", drop3); end
      @(negedge clk);
      checks++; if (drop3 !== 1'b0) begin errors++; $display("FAIL drop_idle got %b want 0", drop3); end
      checks++; if (drop_cnt3 !== 8'd255) begin errors++; $display("FAIL drop_cnt_stay got %0d want 255", drop_cnt3); end
   endtask

   task automatic test_reset_stall();
      @(negedge clk);
      out_ready2 = 2'b00;
      in_valid2 = 1'b1; in_sel2 = 1'b0; in_data2 = 8'h33;
      @(negedge clk);
      in_sel2 = 1'b1; in_data2 = 8'h44;
      @(negedge clk);
      in_valid2 = 1'b0;
      checks++; if (out_valid2 !== 2'b11) begin errors++; $display("FAIL rst_stall_full got %b want 11", out_valid2); end
      checks++; if (out_data2 !== 16'h4433) begin errors++; $display("FAIL rst_stall_data got %h want 4433", out_data2); end
      reset = 1'b1;
      in_valid2 = 1'b1; in_sel2 = 1'b0; in_data2 = 8'h55; out_ready2 = 2'b11;
      #1;
      checks++; if (in_ready2 !== 1'b0) begin errors++; $display("FAIL rst_stall_ready got %b want 0", in_ready2); end
      @(negedge clk);
      checks++; if (out_valid2 !== 2'b00) begin errors++; $display("FAIL rst_stall_cleared got %b want 00", out_valid2); end
      checks++; if (out_data2 !== 16'h0) begin errors++; $display("FAIL rst_stall_data_zero got %h want 0000", out_data2); end
      checks++; if (drop_cnt3 !== 8'd0) begin errors++; $display("FAIL rst_drop_cnt got %0d want 0", drop_cnt3); end
      reset = 1'b0;
      in_sel2 = 1'b1; in_data2 = 8'h66;
      #1;
      checks++; if (in_ready2 !== 1'b1) begin errors++; $display("FAIL resume_ready got %b want 1", in_ready2); end
      @(negedge clk);
      in_valid2 = 1'b0;
      checks++; if (out_valid2 !== 2'b10) begin errors++; $display("FAIL resume_valid got %b want 10", out_valid2); end
      checks++; if (out_data2[15:8] !== 8'h66) begin errors++; $display("FAIL resume_data got %h want 66", out_data2[15:8]); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stall();
      test_back_to_back();
      test_drop();
      test_reset_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached at %0t without completing", $time);
      $fatal(1);
   end

endmodule
